// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, instruction-memory port and IF/ID outputs.
// The fetch stage is the master; the decode/hazard/memory side is the slave.
interface if_fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
    logic        misalign_fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  Instruction,
        output Inst_Address,
        output ifid_pc,
        output ifid_instruction,
        output ifid_valid,
        output misalign_fault,
        output fetch_count
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output Instruction,
        input  Inst_Address,
        input  ifid_pc,
        input  ifid_instruction,
        input  ifid_valid,
        input  misalign_fault,
        input  fetch_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, redirect/stall
// handling, end-of-program halt and sticky misaligned-redirect fault.
//
//   state | meaning
//   FETCH | fetching sequentially from pc, honouring stall and redirects
//   DONE  | pc ran past the end of memory; waits for an aligned redirect
//   FAULT | misaligned redirect seen; frozen until reset
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 16,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic clk,
    input  logic reset,
    if_fetch_stage_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DONE  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] ifid_pc, ifid_pc_nxt;
    logic [31:0] ifid_inst, ifid_inst_nxt;
    logic        ifid_valid, ifid_valid_nxt;
    logic        fault, fault_nxt;
    logic [31:0] fetch_count, fetch_count_nxt;

    logic        in_range;
    logic        target_aligned;

    assign in_range       = (pc <= LAST_PC);
    assign target_aligned = (bus.branch_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            ifid_pc     <= 64'h0;
            ifid_inst   <= NOP_INST;
            ifid_valid  <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ifid_pc     <= ifid_pc_nxt;
            ifid_inst   <= ifid_inst_nxt;
            ifid_valid  <= ifid_valid_nxt;
            fault       <= fault_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ifid_pc_nxt     = ifid_pc;
        ifid_inst_nxt   = ifid_inst;
        ifid_valid_nxt  = ifid_valid;
        fault_nxt       = fault;
        fetch_count_nxt = fetch_count;

        unique case (state)
            FETCH: begin
                if (bus.branch_taken) begin
                    ifid_pc_nxt    = 64'h0;
                    ifid_inst_nxt  = NOP_INST;
                    ifid_valid_nxt = 1'b0;
                    if (target_aligned) begin
                        pc_nxt = bus.branch_target;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end
                end else if (bus.stall) begin
                    // everything holds
                end else if (in_range) begin
                    ifid_pc_nxt     = pc;
                    ifid_inst_nxt   = bus.Instruction;
                    ifid_valid_nxt  = 1'b1;
                    pc_nxt          = pc + 64'd4;
                    fetch_count_nxt = fetch_count + 32'd1;
                end else begin
                    ifid_pc_nxt    = 64'h0;
                    ifid_inst_nxt  = NOP_INST;
                    ifid_valid_nxt = 1'b0;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                // stall deliberately ignored; IF/ID stays empty even on the redirect cycle
                ifid_pc_nxt    = 64'h0;
                ifid_inst_nxt  = NOP_INST;
                ifid_valid_nxt = 1'b0;
                if (bus.branch_taken) begin
                    if (target_aligned) begin
                        pc_nxt    = bus.branch_target;
                        state_nxt = FETCH;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end
                end
            end
            FAULT: begin
                ifid_pc_nxt    = 64'h0;
                ifid_inst_nxt  = NOP_INST;
                ifid_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
    end

    assign bus.Inst_Address     = pc;
    assign bus.ifid_pc          = ifid_pc;
    assign bus.ifid_instruction = ifid_inst;
    assign bus.ifid_valid       = ifid_valid;
    assign bus.misalign_fault   = fault;
    assign bus.fetch_count      = fetch_count;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic checked every cycle against a behavioural model.
module tb_if_fetch_stage;
    logic clk;
    logic reset;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC  (64'h0),
        .IMEM_BYTES(16),
        .NOP_INST  (32'h00000013)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [3:0] i;
        i = a[3:0];
        if (a > 64'd12) return 32'h0;
        return {mem[i + 4'd3], mem[i + 4'd2], mem[i + 4'd1], mem[i]};
    endfunction

    always_comb bus.Instruction = mem_word(bus.Inst_Address);

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = fetching, 1 = halted at end, 2 = faulted.
    int          m_mode;
    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_ifid_inst;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;
    bit          chk_en = 0;

    task automatic m_flush();
        m_ifid_pc   = 64'h0;
        m_ifid_inst = 32'h00000013;
        m_valid     = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_pc = 64'h0; m_fault = 1'b0; m_count = 32'h0;
            m_flush();
        end else if (m_mode == 2) begin
            m_flush();
        end else if (bus.branch_taken) begin
            m_flush();
            if (bus.branch_target % 4 == 0) begin
                m_pc = bus.branch_target;
                m_mode = 0;
            end else begin
                m_fault = 1'b1;
                m_mode = 2;
            end
        end else if (m_mode == 1) begin
            m_flush();
        end else if (bus.stall) begin
            // hold
        end else if (m_pc + 4 <= 16 && m_pc < 64'd16) begin
            m_ifid_pc   = m_pc;
            m_ifid_inst = mem_word(m_pc);
            m_valid     = 1'b1;
            m_pc        = m_pc + 4;
            m_count     = m_count + 1;
        end else begin
            m_flush();
            m_mode = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("Inst_Address", bus.Inst_Address, m_pc);
            check("ifid_pc", bus.ifid_pc, m_ifid_pc);
            check("ifid_instruction", 64'(bus.ifid_instruction), 64'(m_ifid_inst));
            check("ifid_valid", 64'(bus.ifid_valid), 64'(m_valid));
            check("misalign_fault", 64'(bus.misalign_fault), 64'(m_fault));
            check("fetch_count", 64'(bus.fetch_count), 64'(m_count));
        end
    end

    task automatic step(input logic rst_v, input logic st, input logic br, input logic [63:0] tgt);
        reset = rst_v;
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] img [16];
        img = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hb3, 8'h84, 8'h9a, 8'h00,
                8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
        for (int i = 0; i < 16; i++) mem[i] = img[i];

        reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 64'h0;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, 64'h0);
        chk_en = 1;
        check("rst_inst_address", bus.Inst_Address, 64'h0);
        check("rst_ifid_inst", 64'(bus.ifid_instruction), 64'h13);
        check("rst_valid", 64'(bus.ifid_valid), 64'h0);

        // sequential fetch
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("seq0_pc", bus.ifid_pc, 64'h0);
        check("seq0_inst", 64'(bus.ifid_instruction), 64'h02853483);
        check("seq0_valid", 64'(bus.ifid_valid), 64'h1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("seq1_pc", bus.ifid_pc, 64'h4);
        check("seq1_inst", 64'(bus.ifid_instruction), 64'h009a84b3);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("seq2_inst", 64'(bus.ifid_instruction), 64'h00148493);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("seq3_pc", bus.ifid_pc, 64'hc);
        check("seq3_inst", 64'(bus.ifid_instruction), 64'h02953423);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("done_valid", 64'(bus.ifid_valid), 64'h0);
        check("done_pc", bus.Inst_Address, 64'd16);
        check("done_count", 64'(bus.fetch_count), 64'd4);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("done_stall_pc", bus.Inst_Address, 64'd16);

        // stall while ifid_pc = 4
        step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0);
            check("stall_ifid_pc", bus.ifid_pc, 64'h4);
            check("stall_inst", 64'(bus.ifid_instruction), 64'h009a84b3);
            check("stall_pc", bus.Inst_Address, 64'h8);
            check("stall_count", 64'(bus.fetch_count), 64'd2);
        end
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("resume_ifid_pc", bus.ifid_pc, 64'h8);

        // redirect beats stall
        step(1'b1, 1'b1, 1'b1, 64'h0);
        check("redir_valid", 64'(bus.ifid_valid), 64'h0);
        check("redir_inst", 64'(bus.ifid_instruction), 64'h13);
        check("redir_pc", bus.Inst_Address, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("redir_ifid_pc", bus.ifid_pc, 64'h0);
        check("redir_ifid_inst", 64'(bus.ifid_instruction), 64'h02853483);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b1, 64'h4);
        check("done_redir_valid", 64'(bus.ifid_valid), 64'h0);
        check("done_redir_pc", bus.Inst_Address, 64'h4);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("done_redir_ifid_pc", bus.ifid_pc, 64'h4);

        // misaligned target
        step(1'b1, 1'b0, 1'b1, 64'h6);
        check("mis_fault", 64'(bus.misalign_fault), 64'h1);
        check("mis_pc", bus.Inst_Address, 64'h8);
        step(1'b1, 1'b0, 1'b1, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("fault_pc", bus.Inst_Address, 64'h8);
        check("fault_valid", 64'(bus.ifid_valid), 64'h0);

        // reset mid-operation
        step(1'b0, 1'b1, 1'b1, 64'h4);
        check("mid_rst_pc", bus.Inst_Address, 64'h0);
        check("mid_rst_fault", 64'(bus.misalign_fault), 64'h0);
        check("mid_rst_count", 64'(bus.fetch_count), 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("restart_pc", bus.ifid_pc, 64'h0);
        check("restart_valid", 64'(bus.ifid_valid), 64'h1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] tgt;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)       tgt = 64'($urandom_range(0, 5)) * 4;
            else if (r < 8)  tgt = 64'($urandom_range(0, 23));
            else if (r == 8) tgt = 64'hffff_ffff_ffff_fff0;
            else             tgt = {$urandom(), $urandom()};
            step(($urandom_range(0, 40) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 tgt);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
